// File: rtl/string_to_board.sv
// string_to_board: rebuilds a 16 x 20-bit board from ASCII text; define STB_POW2_CHECK_EN to reject non-power-of-two tiles.
// One char per cycle, no backpressure; board/done update on the edge that samples tile 15's terminating separator.
module string_to_board (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   char_in,
  input  logic         char_valid,
  output logic [319:0] board,
  output logic         done,
  output logic         busy,
  output logic         error,
  output logic [4:0]   tile_idx
);

  typedef enum logic [2:0] {IDLE, SEP, NUM, DOT, ERR} state_t;

  state_t         state;
  logic [319:0]   shadow;
  logic [319:0]   shadow_next;
  logic [19:0]    acc;
  logic [19:0]    commit_val;
  logic [24:0]    acc_next;
  logic [8:0]     tile_base;
  logic           is_digit;
  logic           is_dot;
  logic           is_sep;
  logic           val_ok;
  logic           commit;
  logic           fail;

  always_comb begin
    is_digit   = (char_in >= 8'h30) && (char_in <= 8'h39);
    is_dot     = (char_in == 8'h2E);
    is_sep     = (char_in == 8'h20) || (char_in == 8'h7C) || (char_in == 8'h2C) ||
                 (char_in == 8'h0A) || (char_in == 8'h0D);
    // 25 bits holds 1048575*10+9, so overflow is detected before truncation
    acc_next   = ({5'd0, acc} * 25'd10) + {21'd0, char_in[3:0]};
    commit_val = (state == NUM) ? acc : 20'd0;
    tile_base  = {5'd0, tile_idx[3:0]} * 9'd20;
    shadow_next = shadow;
    shadow_next[tile_base +: 20] = commit_val;
`ifdef STB_POW2_CHECK_EN
    val_ok = (commit_val == 20'd0) ||
             (!commit_val[0] && ((commit_val & (commit_val - 20'd1)) == 20'd0));
`else
    val_ok = 1'b1;
`endif

    commit = 1'b0;
    fail   = 1'b0;
    if (!start && char_valid) begin
      case (state)
        SEP: fail = !(is_digit || is_dot || is_sep);
        NUM: begin
          if (is_digit)    fail   = (acc_next > 25'd1048575);
          else if (is_sep) commit = 1'b1;
          else             fail   = 1'b1;
        end
        DOT: begin
          if (is_sep) commit = 1'b1;
          else        fail   = 1'b1;
        end
        default: ;
      endcase
    end
    if (commit && !val_ok) begin
      commit = 1'b0;
      fail   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      board    <= '0;
      shadow   <= '0;
      acc      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
      tile_idx <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= SEP;
        busy     <= 1'b1;
        error    <= 1'b0;
        tile_idx <= '0;
        shadow   <= '0;
        acc      <= '0;
      end else if (fail) begin
        state <= ERR;
        error <= 1'b1;
        busy  <= 1'b0;
      end else if (commit) begin
        shadow   <= shadow_next;
        tile_idx <= tile_idx + 5'd1;
        acc      <= '0;
        if (tile_idx == 5'd15) begin
          board <= shadow_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          state <= SEP;
        end
      end else if (char_valid) begin
        case (state)
          SEP: begin
            if (is_digit) begin
              state <= NUM;
              acc   <= {16'd0, char_in[3:0]};
            end else if (is_dot) begin
              state <= DOT;
            end
          end
          NUM: if (is_digit) acc <= acc_next[19:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/string_to_board.md
# string_to_board

Character-stream parser that rebuilds a 320-bit game board from ASCII text, one character per accepted strobe. It is the inverse of the board serializer: text typed or replayed over the character link (e.g. UART receive side) is converted back into sixteen 20-bit tile values and committed atomically to the game core. Board layout is identical to the serializer's: tile k occupies `board[k*20 +: 20]`, k = 0..15, row-major.

## Interface
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; clears working state and begins a new parse
- `char_in`  in  8  ASCII character
- `char_valid`  in  1  `char_in` valid this cycle; consumed same cycle, no backpressure
- `board`  out  320  last successfully parsed board; tile k at `[k*20 +: 20]`
- `done`  out  1  one-cycle pulse when `board` is updated
- `busy`  out  1  high from `start` until done/error
- `error`  out  1  sticky parse error; cleared only by `start` or `rst`
- `tile_idx`  out  5  number of tiles committed in current parse (0..16)

## Operation
- Reset: `board`=0, `done`=0, `busy`=0, `error`=0, `tile_idx`=0, state IDLE, accumulator 0.
- Character classes:
  - digit `'0'`–`'9'` (0x30–0x39)
  - empty-tile `'.'` (0x2E), value 0
  - separators: space 0x20, `'|'` 0x7C, `','` 0x2C, LF 0x0A, CR 0x0D
  - anything else is illegal
- States:
  - IDLE: characters ignored. `start` → SEP.
  - SEP (between tokens):
    - digit → NUM with acc = digit
    - `'.'` → DOT
    - separator → stay
    - illegal → ERR
  - NUM:
    - digit → acc = acc*10 + digit; compute in 25 bits; if result > 1048575 → ERR
    - separator → commit acc to tile `tile_idx`, increment, → SEP
    - `'.'` or illegal → ERR
  - DOT:
    - separator → commit 0, → SEP
    - anything else → ERR
  - On the commit of tile 15: copy the 320-bit shadow register to `board`, pulse `done`, clear `busy`, → IDLE.
  - ERR: `error`=1, `busy`=0; `board` is unchanged and keeps its last good value; characters ignored until `start`.
- Tiles accumulate in a shadow register. `board` never shows a partial parse.
- Characters after completion are ignored until the next `start`.

## Timing
- One character consumed per cycle when `char_valid`=1; back-to-back strobes are supported.
- Commit latency: the terminating separator of tile 15 is sampled at edge N. `board`, `done`=1 and `busy`=0 are all visible after edge N; `done` returns to 0 after edge N+1.
- `error` and `busy`=0 are visible after the edge that samples the offending character.
- `start` sampled at edge N: after that edge `busy`=1, `error`=0, `tile_idx`=0, shadow=0, acc=0.
- `start` together with `char_valid`: `start` wins and the character is dropped.
- `start` while busy: abort the current parse and restart; `board` is unchanged.
- `rst` mid-parse: full return to reset values, including `board`=0.
- `char_valid`=0: no state change.

## Configuration
- `STB_POW2_CHECK_EN` defined:
  - at each commit, a nonzero tile value must be a power of two ≥ 2 (exactly one bit set, bit 0 clear), otherwise → ERR
  - value 0 is always legal
- Not defined: any value 0..1048575 is accepted.

## Test plan
- Reset then idle: after `rst`, `board`=0, `done`=`busy`=`error`=0; characters with no `start` do nothing.
- Nominal parse: `start`, then `"2 . . . 4 . . . . . 256 . . . . .\n"`:
  - `done` pulses once, exactly one cycle after `'\n'`
  - `board[0+:20]`=2, `board[80+:20]`=4, `board[200+:20]`=256, all other tiles 0, `tile_idx`=16
- Overflow: token `"1048575 "` is accepted as 0xFFFFF; token `"1048576"` raises `error` on its last `'6'`, and `board` keeps its prior value.
- Illegal characters: `'x'` in SEP, `".5"`, and `"12."` each set `error`; the next `start` clears it and a clean 16-tile parse succeeds.
- Abort and collision: `start` after 7 tiles restarts, and only a full 16 further tiles produce `done`; `start` in the same cycle as `'3'` drops the `'3'`.
- With `STB_POW2_CHECK_EN`: tile `"6 "` → `error`, tile `"2048 "` is accepted. Without the macro, `"6 "` is accepted as 6.
